quad_decoder: RTL and testbench

QUAD_DECODER -- requirements
Module: quad_decoder

---
 rtl/quad_decoder.sv | 125 ++++++++++++
 tb/tb_quad_decoder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - quadrature encoder decoder: sync, per-channel glitch filter, step/dir/error
module quad_decoder #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic a_in,
    input  logic b_in,
    input  logic en,
    input  logic clr_err,
    output logic step,
    output logic up,
    output logic err,
    output logic err_sticky
);

    localparam int CW = $clog2(FILT_LEN + 1);
    localparam int IW = $clog2(FILT_LEN + 3);
    localparam logic [CW-1:0] CNT_LAST  = CW'(FILT_LEN - 1);
    localparam logic [IW-1:0] INIT_LAST = IW'(FILT_LEN + 2);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        init_q, init_d;
    logic [1:0]           s1_q, s2_q;
    logic [1:0]           filt_q, filt_d;
    logic [1:0][CW-1:0]   cnt_q, cnt_d;
    logic [1:0]           prev_q;
    logic                 step_q, step_d;
    logic                 up_q, up_d;
    logic                 err_q, err_d;
    logic                 sticky_q, sticky_d;
    logic [1:0]           idx_cur, idx_prev, delta;

    // Each channel only adopts a new level after FILT_LEN consecutive disagreeing samples.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] != filt_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    filt_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Gray-to-binary position: the modulo-4 difference gives +1 forward, -1 reverse, 2 illegal.
    assign idx_cur  = {filt_q[1], filt_q[1] ^ filt_q[0]};
    assign idx_prev = {prev_q[1], prev_q[1] ^ prev_q[0]};
    assign delta    = idx_cur - idx_prev;

    always_comb begin
        state_d = state_q;
        init_d  = init_q;
        step_d  = 1'b0;
        err_d   = 1'b0;
        up_d    = up_q;
        case (state_q)
            ST_INIT: begin
                if (init_q == INIT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    init_d = init_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (en) begin
                    case (delta)
                        2'd1: begin
                            step_d = 1'b1;
                            up_d   = 1'b1;
                        end
                        2'd3: begin
                            step_d = 1'b1;
                            up_d   = 1'b0;
                        end
                        2'd2:    err_d = 1'b1;
                        default: ;
                    endcase
                end
            end
            default: state_d = ST_INIT;
        endcase
        // err_q term keeps the flag set when clr_err coincides with the visible err pulse
        sticky_d = err_d | err_q | (sticky_q & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_INIT;
            init_q   <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            filt_q   <= '0;
            cnt_q    <= '0;
            prev_q   <= '0;
            step_q   <= 1'b0;
            up_q     <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            init_q   <= init_d;
            s1_q     <= {a_in, b_in};
            s2_q     <= s1_q;
            filt_q   <= filt_d;
            cnt_q    <= cnt_d;
            prev_q   <= filt_q;
            step_q   <= step_d;
            up_q     <= up_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
        end
    end

    assign step       = step_q;
    assign up         = up_q;
    assign err        = err_q;
    assign err_sticky = sticky_q;

endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - scoreboard bench for quad_decoder with window-based reference model
module tb_quad_decoder;

    localparam int L = 4;

    logic clk = 1'b0;
    logic rst, a_in, b_in, en, clr_err;
    logic step, up, err, err_sticky;

    always #5 clk = ~clk;

    quad_decoder #(.FILT_LEN(L)) dut (
        .clk        (clk),
        .rst        (rst),
        .a_in       (a_in),
        .b_in       (b_in),
        .en         (en),
        .clr_err    (clr_err),
        .step       (step),
        .up         (up),
        .err        (err),
        .err_sticky (err_sticky)
    );

    typedef struct {
        int cyc;
        bit is_err;
        bit up;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;

    bit [1:0] gseq [4];
    bit [1:0] ms1, ms2, mfilt, mprev, m_nf;
    bit [1:0] win [L];
    int       since, m_d;
    bit       mup, msticky, merr_prev, m_err_now, m_all;

    function automatic int pos(input bit [1:0] ab);
        for (int i = 0; i < 4; i++) if (gseq[i] == ab) return i;
        return 0;
    endfunction

    // Reference: a channel flips once its last L synchronized samples all disagree with it.
    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            ms1 = 0; ms2 = 0; mfilt = 0; mprev = 0;
            for (int k = 0; k < L; k++) win[k] = 2'b00;
            since = 0; mup = 0; msticky = 0; merr_prev = 0;
        end else begin
            since++;
            for (int k = L - 1; k > 0; k--) win[k] = win[k-1];
            win[0] = ms2;
            m_nf = mfilt;
            for (int c = 0; c < 2; c++) begin
                m_all = 1'b1;
                for (int k = 0; k < L; k++) if (win[k][c] == mfilt[c]) m_all = 1'b0;
                if (m_all) m_nf[c] = ~mfilt[c];
            end
            m_d = (pos(mfilt) - pos(mprev) + 4) % 4;
            m_err_now = 1'b0;
            if (since > L + 3 && en) begin
                if (m_d == 1) begin
                    exp_q.push_back('{cyc, 1'b0, 1'b1});
                    mup = 1'b1;
                end else if (m_d == 3) begin
                    exp_q.push_back('{cyc, 1'b0, 1'b0});
                    mup = 1'b0;
                end else if (m_d == 2) begin
                    exp_q.push_back('{cyc, 1'b1, mup});
                    m_err_now = 1'b1;
                end
            end
            msticky   = (m_err_now || merr_prev) ? 1'b1 : (clr_err ? 1'b0 : msticky);
            merr_prev = m_err_now;
            mprev = mfilt;
            mfilt = m_nf;
            ms2   = ms1;
            ms1   = {a_in, b_in};
        end
    end

    always @(negedge clk) begin
        ev_t ev;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            ev = exp_q.pop_front();
            tests++; fails++;
            $display("FAIL missed_event cyc=%0d got step=0 err=0 expected err=%0b up=%0b", ev.cyc, ev.is_err, ev.up);
        end
        if (step || err) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event cyc=%0d got step=%0b err=%0b expected none", cyc, step, err);
            end else begin
                ev = exp_q.pop_front();
                if (ev.cyc != cyc || ev.is_err != err || ev.is_err == step || ev.up != up) begin
                    fails++;
                    $display("FAIL event cyc=%0d got step=%0b err=%0b up=%0b expected cyc=%0d err=%0b up=%0b",
                             cyc, step, err, up, ev.cyc, ev.is_err, ev.up);
                end
            end
        end
        tests++;
        if (up !== mup || err_sticky !== msticky) begin
            fails++;
            $display("FAIL levels cyc=%0d got up=%0b sticky=%0b expected up=%0b sticky=%0b",
                     cyc, up, err_sticky, mup, msticky);
        end
    end

    task automatic hold(input bit [1:0] ab, input int n);
        {a_in, b_in} = ab;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %0b expected %0b", name, got, want);
        end
    endtask

    initial begin
        bit [1:0] cur_ab, nxt;
        int r;
        gseq = '{2'b00, 2'b01, 2'b11, 2'b10};
        rst = 1'b0; a_in = 1'b0; b_in = 1'b0; en = 1'b1; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        check_bit("reset_step", step, 1'b0);
        check_bit("reset_err", err, 1'b0);
        check_bit("reset_up", up, 1'b0);
        check_bit("reset_sticky", err_sticky, 1'b0);
        rst = 1'b1;

        hold(2'b00, 12);
        hold(2'b01, 10); hold(2'b11, 10); hold(2'b10, 10); hold(2'b00, 10);
        hold(2'b10, 10); hold(2'b11, 10); hold(2'b01, 10); hold(2'b00, 10);
        hold(2'b01, 10); hold(2'b00, 10);
        hold(2'b01, 3);  hold(2'b00, 10);
        hold(2'b01, 4);  hold(2'b00, 12);

        hold(2'b11, 10);
        check_bit("illegal_sticky", err_sticky, 1'b1);
        clr_err = 1'b1; hold(2'b11, 1); clr_err = 1'b0;
        hold(2'b11, 3);
        check_bit("clr_sticky", err_sticky, 1'b0);
        hold(2'b00, 7);
        clr_err = 1'b1; hold(2'b00, 1); clr_err = 1'b0;
        hold(2'b00, 3);
        check_bit("err_clr_same_cycle", err_sticky, 1'b1);
        clr_err = 1'b1; hold(2'b00, 1); clr_err = 1'b0;

        rst = 1'b0; hold(2'b11, 3); rst = 1'b1;
        hold(2'b11, 15);
        hold(2'b10, 10);
        check_bit("after_reset_11_10_up", up, 1'b1);

        hold(2'b00, 10);
        en = 1'b0; hold(2'b01, 10); hold(2'b11, 10);
        en = 1'b1; hold(2'b11, 10);
        hold(2'b10, 10);

        cur_ab = 2'b10;
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 9);
            if (r < 4)       nxt = gseq[(pos(cur_ab) + 1) % 4];
            else if (r < 8)  nxt = gseq[(pos(cur_ab) + 3) % 4];
            else if (r == 8) nxt = gseq[(pos(cur_ab) + 2) % 4];
            else             nxt = cur_ab;
            if ($urandom_range(0, 9) == 0) en = ~en;
            clr_err = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 29) != 0);
            hold(nxt, $urandom_range(1, 14));
            rst = 1'b1;
            cur_ab = nxt;
        end

        en = 1'b1; clr_err = 1'b0; rst = 1'b1;
        hold(cur_ab, 20);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
